// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: decode, regfile read with N-channel forwarding, load-use
// hazard detection, BEZ resolution, post-branch squash and a registered ID/EX bundle.
// Optional illegal-opcode trap (illegal_op / illegal_cnt) is built with `define ILLEGAL_TRAP_EN.
module id_stage_pipe #(
  parameter int DATA_W     = 16,
  parameter int FWD_CH     = 2,
  parameter int SQUASH_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  input  logic [15:0]              instruction,
  input  logic                     stall_in,
  output logic [2:0]               reg_read_addr_1,
  output logic [2:0]               reg_read_addr_2,
  input  logic [DATA_W-1:0]        reg_read_data_1,
  input  logic [DATA_W-1:0]        reg_read_data_2,
  input  logic [FWD_CH-1:0]        fw_valid,
  input  logic [3*FWD_CH-1:0]      fw_addr,
  input  logic [DATA_W*FWD_CH-1:0] fw_data,
  input  logic                     ex_load_valid,
  input  logic [2:0]               ex_load_dst,
  output logic                     stall_out,
  output logic                     branch_taken,
  output logic [5:0]               branch_offset_imm,
  output logic [3*DATA_W+8:0]      pipeline_reg_output
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                     illegal_op,
  output logic [7:0]               illegal_cnt
`endif
);

  localparam logic [3:0] OP_ADDI  = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_STORE = 4'd11;
  localparam logic [3:0] OP_BEZ   = 4'd12;
  localparam logic [1:0] SQ_LOAD  = 2'(SQUASH_CYC);

  // ID/EX bundle, MSB first; alu_op is 0 for every non-ALU opcode.
  typedef struct packed {
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              is_store;
    logic [DATA_W-1:0] store_data;
    logic              wb_en;
    logic [2:0]        wb_addr;
    logic              alu_sel;
  } id_ex_t;

  logic [3:0]        opcode;
  logic [2:0]        rd, rs2, rs1;
  logic [5:0]        imm;
  logic [DATA_W-1:0] imm_sext;
  logic              is_alu, is_mem_imm, is_store, is_bez;
  logic              uses_rs1, uses_rs2, uses_rd;
  logic              load_hit, hazard, squash_active;
  logic [DATA_W-1:0] op1, op2;
  logic [1:0]        squash_cnt;
  id_ex_t            decoded, pipe_q;

  assign opcode   = instruction[15:12];
  assign rd       = instruction[11:9];
  assign rs2      = instruction[8:6];
  assign rs1      = instruction[5:3];
  assign imm      = instruction[5:0];
  assign imm_sext = {{(DATA_W-6){imm[5]}}, imm};

  assign is_alu     = (opcode >= 4'd1) && (opcode <= 4'd8);
  assign is_mem_imm = (opcode == OP_ADDI) || (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign is_store   = (opcode == OP_STORE);
  assign is_bez     = (opcode == OP_BEZ);

  assign reg_read_addr_1   = is_store ? rd : rs1;
  assign reg_read_addr_2   = rs2;
  assign branch_offset_imm = imm;

  // Walk channels from highest index down so the lowest matching index wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    op1 = reg_read_data_1;
    op2 = reg_read_data_2;
    for (int i = FWD_CH - 1; i >= 0; i--) begin
      if (fw_valid[i] && (fw_addr[3*i +: 3] == reg_read_addr_1)) op1 = fw_data[DATA_W*i +: DATA_W];
      if (fw_valid[i] && (fw_addr[3*i +: 3] == reg_read_addr_2)) op2 = fw_data[DATA_W*i +: DATA_W];
    end
    if (reg_read_addr_1 == 3'd0) op1 = '0;
    if (reg_read_addr_2 == 3'd0) op2 = '0;
  end

  // Only sources the opcode really consumes can cause a load-use stall.
  assign uses_rs1 = is_alu;
  assign uses_rs2 = is_alu || (opcode == OP_ADDI) || is_store || is_bez;
  assign uses_rd  = is_store;
  assign load_hit = ex_load_valid && (ex_load_dst != 3'd0) &&
                    ((uses_rs1 && (ex_load_dst == rs1)) ||
                     (uses_rs2 && (ex_load_dst == rs2)) ||
                     (uses_rd  && (ex_load_dst == rd)));

  assign squash_active = (squash_cnt != 2'd0);
  assign hazard        = instr_valid && load_hit && !squash_active;
  assign stall_out     = rst && (stall_in || hazard);
  assign branch_taken  = rst && !stall_in && instr_valid && !squash_active && !hazard &&
                         is_bez && (op2 == '0);

  // NOP, BEZ and illegal opcodes all decode to the all-zero bubble.
  always_comb begin
    decoded = '0;
    if (is_alu || is_mem_imm) begin
      decoded.alu_op     = is_alu ? 3'(opcode - 4'd1) : 3'd0;
      decoded.opa        = is_mem_imm ? op2 : op1;
      decoded.opb        = is_mem_imm ? imm_sext : op2;
      decoded.is_store   = is_store;
      decoded.store_data = op1;
      decoded.wb_en      = !is_store;
      decoded.wb_addr    = is_store ? 3'd0 : rd;
      decoded.alu_sel    = is_alu || (opcode == OP_ADDI);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      pipe_q     <= '0;
      squash_cnt <= '0;
    end else if (!stall_in) begin
      if (squash_active || !instr_valid || hazard) pipe_q <= '0;
      else                                         pipe_q <= decoded;
      if (branch_taken)       squash_cnt <= SQ_LOAD;
      else if (squash_active) squash_cnt <= squash_cnt - 2'd1;
    end
  end

  assign pipeline_reg_output = pipe_q;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_event;

  assign illegal_event = rst && !stall_in && instr_valid && !squash_active && (opcode >= 4'd13);

  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_op  <= 1'b0;
      illegal_cnt <= 8'd0;
    end else if (illegal_event) begin
      illegal_op <= 1'b1;
      if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vector table, multi-cycle squash/reset
// sequences, and randomized traffic compared with a behavioural model.
module tb_id_stage_pipe;
  localparam int DATA_W = 16;
  localparam int FWD_CH = 2;
  localparam int SQ     = 2;
  localparam int BW     = 3*DATA_W + 9;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     instr_valid;
  logic [15:0]              instruction;
  logic                     stall_in;
  logic [2:0]               reg_read_addr_1, reg_read_addr_2;
  logic [DATA_W-1:0]        reg_read_data_1, reg_read_data_2;
  logic [FWD_CH-1:0]        fw_valid;
  logic [3*FWD_CH-1:0]      fw_addr;
  logic [DATA_W*FWD_CH-1:0] fw_data;
  logic                     ex_load_valid;
  logic [2:0]               ex_load_dst;
  logic                     stall_out, branch_taken;
  logic [5:0]               branch_offset_imm;
  logic [BW-1:0]            pipeline_reg_output;
`ifdef ILLEGAL_TRAP_EN
  logic                     illegal_op;
  logic [7:0]               illegal_cnt;
`endif

  logic [15:0] rf [8];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [BW-1:0] m_q;
  int            m_sq;
  bit            m_ill;
  int            m_cnt;

  id_stage_pipe #(.DATA_W(DATA_W), .FWD_CH(FWD_CH), .SQUASH_CYC(SQ)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .stall_in(stall_in), .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
    .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
    .fw_valid(fw_valid), .fw_addr(fw_addr), .fw_data(fw_data),
    .ex_load_valid(ex_load_valid), .ex_load_dst(ex_load_dst),
    .stall_out(stall_out), .branch_taken(branch_taken),
    .branch_offset_imm(branch_offset_imm), .pipeline_reg_output(pipeline_reg_output)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  // The register file answers whatever address the stage asks for.
  always_comb begin
    reg_read_data_1 = rf[reg_read_addr_1];
    reg_read_data_2 = rf[reg_read_addr_2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] bnd(input logic [2:0] alu, input logic [15:0] a,
      input logic [15:0] b, input logic st, input logic [15:0] sd, input logic [3:0] wb,
      input logic sel);
    return {alu, a, b, st, sd, wb, sel};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] m_operand(input int addr);
    if (addr == 0) return 16'h0;
    for (int c = 0; c < FWD_CH; c++)
      if (fw_valid[c] && (int'(fw_addr[3*c +: 3]) == addr)) return fw_data[16*c +: 16];
    return rf[addr];
  endfunction

  function automatic bit m_hazard(input logic [15:0] ins);
    int op, rd, rs2, rs1, d;
    bit hit;
    op = int'(ins[15:12]); rd = int'(ins[11:9]); rs2 = int'(ins[8:6]); rs1 = int'(ins[5:3]);
    d = int'(ex_load_dst);
    hit = 0;
    if (!ex_load_valid || d == 0) return 0;
    if (op >= 1 && op <= 8 && d == rs1) hit = 1;
    if (((op >= 1 && op <= 9) || op == 11 || op == 12) && d == rs2) hit = 1;
    if (op == 11 && d == rd) hit = 1;
    return hit;
  endfunction

  function automatic logic [BW-1:0] m_decode(input logic [15:0] ins);
    int op, rd;
    logic [15:0] a, b, simm;
    op   = int'(ins[15:12]);
    rd   = int'(ins[11:9]);
    a    = m_operand(op == 11 ? rd : int'(ins[5:3]));
    b    = m_operand(int'(ins[8:6]));
    simm = {{10{ins[5]}}, ins[5:0]};
    if (op >= 1 && op <= 8) return bnd(3'(op - 1), a, b, 1'b0, a, 4'(8 + rd), 1'b1);
    if (op == 9)            return bnd(3'd0, b, simm, 1'b0, a, 4'(8 + rd), 1'b1);
    if (op == 10)           return bnd(3'd0, b, simm, 1'b0, a, 4'(8 + rd), 1'b0);
    if (op == 11)           return bnd(3'd0, b, simm, 1'b1, a, 4'd0, 1'b0);
    return '0;
  endfunction

  // One clock with inputs already driven: check combinational outputs, then the register.
  task automatic run_cycle(input string tag, output bit got_stall, output bit got_br,
                           output logic [BW-1:0] got_q);
    bit sq, hz, e_stall, e_br, ill_ev;
    logic [BW-1:0] nq;
    int nsq, op, e_a1;
    op = int'(instruction[15:12]);
    #2;
    sq      = (m_sq > 0);
    hz      = instr_valid && !sq && m_hazard(instruction);
    e_stall = rst && (stall_in || hz);
    e_br    = rst && !stall_in && instr_valid && !sq && !hz && op == 12 &&
              m_operand(int'(instruction[8:6])) == 16'h0;
    e_a1    = (op == 11) ? int'(instruction[11:9]) : int'(instruction[5:3]);
    check({tag, ".stall_out"}, 64'(stall_out), 64'(e_stall));
    check({tag, ".branch_taken"}, 64'(branch_taken), 64'(e_br));
    check({tag, ".addr1"}, 64'(reg_read_addr_1), 64'(e_a1));
    check({tag, ".addr2"}, 64'(reg_read_addr_2), 64'(instruction[8:6]));
    check({tag, ".offset"}, 64'(branch_offset_imm), 64'(instruction[5:0]));
    got_stall = stall_out;
    got_br    = branch_taken;
    nq = m_q; nsq = m_sq; ill_ev = 0;
    if (!rst) begin
      nq = '0; nsq = 0;
    end else if (!stall_in) begin
      nq     = (sq || !instr_valid || hz) ? '0 : m_decode(instruction);
      nsq    = e_br ? SQ : (sq ? m_sq - 1 : 0);
      ill_ev = instr_valid && !sq && op >= 13;
    end
    @(posedge clk);
    m_q = nq; m_sq = nsq;
    if (!rst) begin m_ill = 0; m_cnt = 0; end
    else if (ill_ev) begin m_ill = 1; if (m_cnt < 255) m_cnt++; end
    #1;
    check({tag, ".bundle"}, 64'(pipeline_reg_output), 64'(m_q));
    got_q = pipeline_reg_output;
`ifdef ILLEGAL_TRAP_EN
    check({tag, ".illegal_op"}, 64'(illegal_op), 64'(m_ill));
    check({tag, ".illegal_cnt"}, 64'(illegal_cnt), 64'(m_cnt));
`endif
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [15:0] ins, input logic v, input logic st,
                       input logic lv, input logic [2:0] ld);
    rst = r; instruction = ins; instr_valid = v; stall_in = st;
    ex_load_valid = lv; ex_load_dst = ld;
  endtask

  task automatic set_fw(input logic [1:0] v, input logic [5:0] a, input logic [31:0] d);
    fw_valid = v; fw_addr = a; fw_data = d;
  endtask

  task automatic fixed_rf();
    rf = '{16'h0F0F, 16'h1111, 16'h1234, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
  endtask

  task automatic random_inputs(input bit allow_reset);
    for (int i = 0; i < 8; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    instruction = 16'($urandom);
    if ($urandom_range(0, 5) == 0) instruction[15:12] = 4'hC;
    instr_valid   = ($urandom_range(0, 9) != 0);
    stall_in      = ($urandom_range(0, 6) == 0);
    fw_valid      = 2'($urandom);
    fw_addr       = 6'($urandom);
    fw_data       = ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom);
    ex_load_valid = ($urandom_range(0, 2) == 0);
    ex_load_dst   = 3'($urandom);
    rst           = allow_reset ? ($urandom_range(0, 49) != 0) : 1'b1;
  endtask

  typedef struct {
    string         name;
    logic [15:0]   ins;
    bit            v, st;
    logic [1:0]    fv;
    logic [5:0]    fa;
    logic [31:0]   fd;
    bit            lv;
    logic [2:0]    ld;
    bit            e_stall, e_br;
    logic [BW-1:0] e_q;
  } vec_t;

  function automatic vec_t mk(string nm, logic [15:0] ins, bit v, bit st, logic [1:0] fv,
      logic [5:0] fa, logic [31:0] fd, bit lv, logic [2:0] ld, bit es, bit eb, logic [BW-1:0] eq);
    vec_t t;
    t.name = nm; t.ins = ins; t.v = v; t.st = st; t.fv = fv; t.fa = fa; t.fd = fd;
    t.lv = lv; t.ld = ld; t.e_stall = es; t.e_br = eb; t.e_q = eq;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [BW-1:0] alu_rf, st_b, ld_b, q;
    bit s, b;

    alu_rf = bnd(3'd0, 16'h3333, 16'h1234, 1'b0, 16'h3333, 4'hD, 1'b1);
    ld_b   = bnd(3'd0, 16'h5555, 16'h0005, 1'b0, 16'h0000, 4'hB, 1'b0);
    st_b   = bnd(3'd0, 16'h1111, 16'h001F, 1'b1, 16'hCAFE, 4'h0, 1'b0);
    tbl.push_back(mk("alu_fwd_ch0", 16'h1A98, 1, 0, 2'b11, {3'd3, 3'd3}, {16'h00FF, 16'h0011}, 0, 3'd0,
                     0, 0, bnd(3'd0, 16'h0011, 16'h1234, 1'b0, 16'h0011, 4'hD, 1'b1)));
    tbl.push_back(mk("alu_fwd_ch1", 16'h1A98, 1, 0, 2'b10, {3'd3, 3'd3}, {16'h00FF, 16'h0011}, 0, 3'd0,
                     0, 0, bnd(3'd0, 16'h00FF, 16'h1234, 1'b0, 16'h00FF, 4'hD, 1'b1)));
    tbl.push_back(mk("alu_rf", 16'h1A98, 1, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0, 0, 0, alu_rf));
    tbl.push_back(mk("fwd_rs2", 16'h1A98, 1, 0, 2'b10, {3'd2, 3'd0}, {16'hABCD, 16'h0}, 0, 3'd0,
                     0, 0, bnd(3'd0, 16'h3333, 16'hABCD, 1'b0, 16'h3333, 4'hD, 1'b1)));
    tbl.push_back(mk("r0_no_fwd", 16'h8300, 1, 0, 2'b01, 6'd0, {16'h0, 16'hBEEF}, 0, 3'd0,
                     0, 0, bnd(3'd7, 16'h0, 16'h4444, 1'b0, 16'h0, 4'h9, 1'b1)));
    tbl.push_back(mk("addi_neg", 16'h9DFE, 1, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0,
                     0, 0, bnd(3'd0, 16'h7777, 16'hFFFE, 1'b0, 16'h7777, 4'hE, 1'b1)));
    tbl.push_back(mk("load", 16'hA745, 1, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0, 0, 0, ld_b));
    tbl.push_back(mk("store_fwd_rd", 16'hB45F, 1, 0, 2'b11, {3'd2, 3'd5}, {16'hCAFE, 16'h5A5A}, 0, 3'd0,
                     0, 0, st_b));
    tbl.push_back(mk("stall_hold", 16'h1A98, 1, 1, 2'b00, 6'd0, 32'h0, 0, 3'd0, 1, 0, st_b));
    tbl.push_back(mk("invalid", 16'h1A98, 0, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0, 0, 0, '0));
    tbl.push_back(mk("loaduse_rs1", 16'h1A98, 1, 0, 2'b00, 6'd0, 32'h0, 1, 3'd3, 1, 0, '0));
    tbl.push_back(mk("loaduse_rs2", 16'h1A98, 1, 0, 2'b00, 6'd0, 32'h0, 1, 3'd2, 1, 0, '0));
    tbl.push_back(mk("load_rs2_nohz", 16'hA745, 1, 0, 2'b00, 6'd0, 32'h0, 1, 3'd5, 0, 0, ld_b));
    tbl.push_back(mk("dst0_nohz", 16'h8300, 1, 0, 2'b00, 6'd0, 32'h0, 1, 3'd0,
                     0, 0, bnd(3'd7, 16'h0, 16'h4444, 1'b0, 16'h0, 4'h9, 1'b1)));
    tbl.push_back(mk("store_rd_hz", 16'hB45F, 1, 0, 2'b00, 6'd0, 32'h0, 1, 3'd2, 1, 0, '0));
    tbl.push_back(mk("dst_is_rd_nohz", 16'h1A98, 1, 0, 2'b00, 6'd0, 32'h0, 1, 3'd5, 0, 0, alu_rf));
    tbl.push_back(mk("nop_fields", 16'h0FFF, 1, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0, 0, 0, '0));
    tbl.push_back(mk("bez_not_taken", 16'hC080, 1, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0, 0, 0, '0));
    tbl.push_back(mk("bez_hazard", 16'hC080, 1, 0, 2'b01, {3'd0, 3'd2}, 32'h0, 1, 3'd2, 1, 0, '0));
    tbl.push_back(mk("illegal_nop", 16'hD249, 1, 0, 2'b00, 6'd0, 32'h0, 0, 3'd0, 0, 0, '0));

    // Reset with random inputs for two cycles.
    set_fw(2'b00, 6'd0, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      random_inputs(0);
      rst = 1'b0;
      run_cycle("reset", s, b, q);
      check("reset.stall_zero", 64'(s), 64'd0);
      check("reset.bundle_zero", 64'(q), 64'd0);
    end

    // Directed vector table.
    fixed_rf();
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].ins, tbl[i].v, tbl[i].st, tbl[i].lv, tbl[i].ld);
      set_fw(tbl[i].fv, tbl[i].fa, tbl[i].fd);
      #2;
      check({tbl[i].name, ".stall_out"}, 64'(stall_out), 64'(tbl[i].e_stall));
      check({tbl[i].name, ".branch_taken"}, 64'(branch_taken), 64'(tbl[i].e_br));
      @(posedge clk);
      #1;
      check({tbl[i].name, ".bundle"}, 64'(pipeline_reg_output), 64'(tbl[i].e_q));
      @(negedge clk);
    end

    // Load-use stall then release.
    set_fw(2'b00, 6'd0, 32'h0);
    drive(1'b0, 16'h0000, 0, 0, 0, 3'd0); run_cycle("lu_rst", s, b, q);
    drive(1'b1, 16'h1A98, 1, 0, 1, 3'd3); run_cycle("lu_hit", s, b, q);
    check("lu_hit.stall", 64'(s), 64'd1);
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd3); run_cycle("lu_clear", s, b, q);
    check("lu_clear.decoded", 64'(q), 64'(alu_rf));

    // Taken BEZ, two squashed slots (one carrying a hazard), then normal decode.
    set_fw(2'b01, {3'd0, 3'd2}, 32'h0);
    drive(1'b1, 16'hC080, 1, 0, 0, 3'd0); run_cycle("bez_taken", s, b, q);
    check("bez_taken.flag", 64'(b), 64'd1);
    check("bez_taken.bubble", 64'(q), 64'd0);
    set_fw(2'b00, 6'd0, 32'h0);
    drive(1'b1, 16'h1A98, 1, 0, 1, 3'd3); run_cycle("sq1_hz", s, b, q);
    check("sq1_hz.no_stall", 64'(s), 64'd0);
    check("sq1_hz.bubble", 64'(q), 64'd0);
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("sq2", s, b, q);
    check("sq2.bubble", 64'(q), 64'd0);
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("sq_done", s, b, q);
    check("sq_done.decoded", 64'(q), 64'(alu_rf));

    // stall_in in the middle of a squash window keeps the remaining slot.
    set_fw(2'b01, {3'd0, 3'd2}, 32'h0);
    drive(1'b1, 16'hC080, 1, 0, 0, 3'd0); run_cycle("bez2", s, b, q);
    set_fw(2'b00, 6'd0, 32'h0);
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("bez2_sq1", s, b, q);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h1A98, 1, 1, 0, 3'd0); run_cycle("bez2_hold", s, b, q);
      check("bez2_hold.stall", 64'(s), 64'd1);
    end
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("bez2_sq2", s, b, q);
    check("bez2_sq2.bubble", 64'(q), 64'd0);
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("bez2_done", s, b, q);
    check("bez2_done.decoded", 64'(q), 64'(alu_rf));

    // Reset in the middle of a squash window.
    set_fw(2'b01, {3'd0, 3'd2}, 32'h0);
    drive(1'b1, 16'hC080, 1, 0, 0, 3'd0); run_cycle("bez3", s, b, q);
    set_fw(2'b00, 6'd0, 32'h0);
    drive(1'b0, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("bez3_rst", s, b, q);
    drive(1'b1, 16'h1A98, 1, 0, 0, 3'd0); run_cycle("bez3_after", s, b, q);
    check("bez3_after.decoded", 64'(q), 64'(alu_rf));

`ifdef ILLEGAL_TRAP_EN
    drive(1'b0, 16'h0000, 0, 0, 0, 3'd0); run_cycle("ill_rst", s, b, q);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hE000, 1, 0, 0, 3'd0); run_cycle("ill", s, b, q);
      check("ill.bundle_zero", 64'(q), 64'd0);
    end
    check("ill.sticky", 64'(illegal_op), 64'd1);
    check("ill.count3", 64'(illegal_cnt), 64'd3);
`endif

    // Randomized traffic against the model.
    drive(1'b0, 16'h0000, 0, 0, 0, 3'd0); run_cycle("rand_rst", s, b, q);
    for (int i = 0; i < 600; i++) begin
      random_inputs(1);
      run_cycle("rand", s, b, q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
